// File: rtl/sensor_scan_sched_pkg.sv
// Shared constants, FSM state type and sample-select helper for the
// sensor change-detect scan scheduler.
package sensor_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE
  } state_e;

  function automatic logic [DATA_W-1:0] pick_sample(
    input logic [NUM_CH*DATA_W-1:0] s,
    input logic [CH_W-1:0]          idx
  );
    pick_sample = s[int'(idx)*int'(DATA_W) +: DATA_W];
  endfunction

endpackage

// File: rtl/sensor_scan_sched_rr_arbiter4.sv
// Combinational 4-way round-robin pick: the first eligible requester after
// ptr wins; masked requesters are skipped.
module rr_arbiter4
  import sensor_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic              valid,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [CH_W-1:0]   grant_idx
);

  logic [NUM_CH-1:0] eligible;
  logic [CH_W-1:0]   cand;

  always_comb begin
    valid     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    eligible  = req & ~mask;
    // Offset NUM_CH wraps back to ptr itself, so it has lowest priority.
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = ptr + CH_W'(i);
      if (!valid && eligible[cand]) begin
        valid           = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_sched.sv
// Round-robin scheduler sharing one change-detect co-processor between four
// sample producers, with sticky event flags, event counter and host irq.
module sensor_scan_sched
  import sensor_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  output logic [NUM_CH-1:0]        ack,
  output logic [CH_W-1:0]          cp_check,
  output logic [DATA_W-1:0]        cp_data,
  input  logic                     cp_q,
  output logic [NUM_CH-1:0]        event_flags,
  input  logic [NUM_CH-1:0]        event_clr,
  input  logic                     irq_en,
  output logic                     irq,
  output logic [CNT_W-1:0]         evt_count,
  input  logic                     cnt_clr,
  output logic                     busy
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     check_q, check_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   flags_q, flags_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_CH-1:0]   arb_mask;
  logic                arb_valid;
  logic [NUM_CH-1:0]   arb_oh;
  logic [CH_W-1:0]     arb_idx;
  logic [NUM_CH-1:0]   set_mask;
  logic                inc;

  // The channel being acked still holds req during CAPTURE.
  assign arb_mask = (state_q == ST_CAPTURE) ? ack_q : '0;

  rr_arbiter4 u_arb (
    .req       (req),
    .mask      (arb_mask),
    .ptr       (ptr_q),
    .valid     (arb_valid),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    check_d  = check_q;
    data_d   = data_q;
    ack_d    = '0;
    set_mask = '0;
    inc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_ISSUE;
          ptr_d   = arb_idx;
          check_d = arb_idx;
          data_d  = pick_sample(sample_in, arb_idx);
        end
      end
      ST_ISSUE: begin
        ack_d[check_q] = 1'b1;
        state_d        = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (cp_q) begin
          set_mask[check_q] = 1'b1;
          inc               = 1'b1;
        end
        if (arb_valid) begin
          state_d = ST_ISSUE;
          ptr_d   = arb_idx;
          check_d = arb_idx;
          data_d  = pick_sample(sample_in, arb_idx);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    flags_d = (flags_q & ~event_clr) | set_mask;

    if (cnt_clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_W'(NUM_CH - 1);
      check_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      check_q <= check_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign cp_check    = check_q;
  assign cp_data     = data_q;
  assign event_flags = flags_q;
  assign evt_count   = cnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign irq         = irq_en & (|flags_q);

  logic unused_arb_oh;
  assign unused_arb_oh = |arb_oh;

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Directed and randomized checks of sensor_scan_sched against a
// transaction-level round-robin / event-count model.
module tb_sensor_scan_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] sample_in;
  logic [3:0]  ack;
  logic [1:0]  cp_check;
  logic [7:0]  cp_data;
  logic        cp_q;
  logic [3:0]  event_flags;
  logic [3:0]  event_clr;
  logic        irq_en;
  logic        irq;
  logic [7:0]  evt_count;
  logic        cnt_clr;
  logic        busy;

  sensor_scan_sched #(.CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .sample_in   (sample_in),
    .ack         (ack),
    .cp_check    (cp_check),
    .cp_data     (cp_data),
    .cp_q        (cp_q),
    .event_flags (event_flags),
    .event_clr   (event_clr),
    .irq_en      (irq_en),
    .irq         (irq),
    .evt_count   (evt_count),
    .cnt_clr     (cnt_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         m_ptr;
  logic [3:0] m_flags;
  int         m_count;

  logic [3:0] prev_ack;
  logic       plan [4];
  int         clr_ch;
  int         cntclr_ch;
  int         cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: producers drop req after their ack, and cp_q / coincident
  // clears are driven during the CAPTURE (ack-visible) cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    req       = req & ~prev_ack;
    event_clr = '0;
    cnt_clr   = 1'b0;
    cp_q      = 1'b0;
    prev_ack  = ack;
    for (int n = 0; n < 4; n++) begin
      if (ack[n] === 1'b1) begin
        cp_q = plan[n];
        if (clr_ch == n) event_clr[n] = 1'b1;
        if (cntclr_ch == n) cnt_clr = 1'b1;
      end
    end
  endtask

  task automatic run_batch(input logic [3:0] mask);
    int ord [4];
    int n      = 0;
    int acks   = 0;
    int issues = 0;
    for (int k = 1; k <= 4; k++) begin
      int ch = (m_ptr + k) % 4;
      if (mask[ch]) begin
        ord[n] = ch;
        n++;
      end
    end
    req = mask;
    cyc = 0;
    while (acks < n && cyc < 4 * n + 6) begin
      cycle();
      if (ack !== 4'b0000) begin
        check("ack_chan", {28'd0, ack}, 32'(1) << ord[acks]);
        check("ack_time", cyc, 2 + 2 * acks);
        acks++;
      end else if (busy === 1'b1) begin
        if (issues < n) begin
          check("cp_check", {30'd0, cp_check}, ord[issues]);
          check("cp_data", {24'd0, cp_data}, {24'd0, sample_in[8*ord[issues] +: 8]});
          check("issue_time", cyc, 1 + 2 * issues);
        end else begin
          check("extra_issue", issues, n);
        end
        issues++;
      end
    end
    check("batch_acks", acks, n);
    cycle();
    cycle();
    for (int i = 0; i < n; i++) begin
      int ch = ord[i];
      if (clr_ch == ch) m_flags[ch] = 1'b0;
      if (plan[ch]) begin
        m_flags[ch] = 1'b1;
        if (m_count < 255) m_count++;
      end
      if (cntclr_ch == ch) m_count = 0;
    end
    if (n > 0) m_ptr = ord[n-1];
    clr_ch    = -1;
    cntclr_ch = -1;
    check("flags", {28'd0, event_flags}, {28'd0, m_flags});
    check("count", {24'd0, evt_count}, m_count);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_ack", {28'd0, ack}, 0);
    check("irq", {31'd0, irq}, (irq_en && m_flags != 4'b0000) ? 1 : 0);
  endtask

  task automatic clr_pulse(input logic [3:0] mask);
    event_clr = mask;
    @(posedge clk);
    #1;
    event_clr = '0;
    m_flags   = m_flags & ~mask;
    check("clr_flags", {28'd0, event_flags}, {28'd0, m_flags});
    check("clr_irq", {31'd0, irq}, (irq_en && m_flags != 4'b0000) ? 1 : 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   {28'd0, ack}, 0);
    check({tag, "_check"}, {30'd0, cp_check}, 0);
    check({tag, "_data"},  {24'd0, cp_data}, 0);
    check({tag, "_flags"}, {28'd0, event_flags}, 0);
    check({tag, "_count"}, {24'd0, evt_count}, 0);
    check({tag, "_busy"},  {31'd0, busy}, 0);
    check({tag, "_irq"},   {31'd0, irq}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    sample_in = '0;
    cp_q      = 1'b0;
    event_clr = '0;
    irq_en    = 1'b1;
    cnt_clr   = 1'b0;
    prev_ack  = '0;
    clr_ch    = -1;
    cntclr_ch = -1;
    for (int i = 0; i < 4; i++) plan[i] = 1'b0;
    m_ptr   = 3;
    m_flags = '0;
    m_count = 0;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Channel 0, sample 5, change detected.
    sample_in[7:0] = 8'd5;
    plan[0] = 1'b1;
    run_batch(4'b0001);

    // Channel 0, sample 7, no change; then clear its flag.
    sample_in[7:0] = 8'd7;
    plan[0] = 1'b0;
    run_batch(4'b0001);
    clr_pulse(4'b0001);

    // All four channels back-to-back.
    sample_in = {8'd40, 8'd30, 8'd20, 8'd10};
    for (int i = 0; i < 4; i++) plan[i] = 1'b1;
    run_batch(4'b1111);

    // Set and clear on the same flag bit: set wins.
    clr_pulse(4'b0100);
    plan[2] = 1'b1;
    clr_ch  = 2;
    run_batch(4'b0100);

    // Increment coincident with counter clear: clear wins.
    plan[1]   = 1'b1;
    cntclr_ch = 1;
    run_batch(4'b0010);

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      logic [3:0] m;
      m         = 4'($urandom_range(1, 15));
      sample_in = $urandom;
      irq_en    = 1'($urandom);
      for (int i = 0; i < 4; i++) plan[i] = 1'($urandom);
      if ($urandom_range(0, 3) == 0) clr_pulse(4'($urandom));
      run_batch(m);
    end

    // Drive the counter into saturation, then one more event.
    irq_en = 1'b1;
    for (int b = 0; b < 400 && m_count < 255; b++) begin
      sample_in = $urandom;
      for (int i = 0; i < 4; i++) plan[i] = 1'b1;
      run_batch(4'($urandom_range(1, 15)));
    end
    check("sat_reached", m_count, 255);
    plan[0] = 1'b1;
    run_batch(4'b0001);
    check("sat_hold", {24'd0, evt_count}, 255);

    // Reset during ISSUE of a channel-1 transaction.
    sample_in[15:8] = 8'hA5;
    req = 4'b0010;
    cyc = 0;
    cycle();
    check("pre_rst_busy", {31'd0, busy}, 1);
    check("pre_rst_check", {30'd0, cp_check}, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check("midrst_noack", {28'd0, ack}, 0);
    reset    = 1'b0;
    prev_ack = '0;
    m_ptr    = 3;
    m_flags  = '0;
    m_count  = 0;
    plan[0]  = 1'b1;
    plan[1]  = 1'b0;
    run_batch(4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_scan_sched.md
Name: sensor_scan_sched

Overview:
- Round-robin scheduler that shares the 4-channel sensor change-detect co-processor between four independent sample producers.
- Per transaction: grants one requester, drives its channel index and 8-bit sample onto the co-processor, captures the resulting change flag, and acknowledges the producer.
- Keeps sticky per-channel event flags, a saturating event counter and an interrupt for the host.
- Sits between the sensor front-ends and the co-processor instance.

Parameters:
- NUM_CH, 4, number of requesters. Fixed at 4 to match the co-processor's 2-bit channel select; other values are unsupported.
- DATA_W, 8, sample width. Fixed at 8 to match the co-processor data input.
- CNT_W, 8, width of the saturating event counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  4  per-channel request; held high with the sample stable until the matching ack
- sample_in  input  32  channel n sample on bits [8n+7:8n]
- ack  output  4  one-cycle completion pulse per channel
- cp_check  output  2  channel select to co-processor check input
- cp_data  output  8  sample to co-processor r0 input
- cp_q  input  1  co-processor Q output
- event_flags  output  4  sticky per-channel change-detected flags
- event_clr  input  4  write-1-to-clear for event_flags
- irq_en  input  1  interrupt enable
- irq  output  1  high when irq_en is high and any event_flags bit is set (combinational)
- evt_count  output  CNT_W  saturating total of captured events
- cnt_clr  input  1  synchronous clear of evt_count
- busy  output  1  high in ISSUE or CAPTURE

Behaviour:
- Reset value of every output is 0: ack, cp_check, cp_data, event_flags, evt_count, busy, irq. FSM returns to IDLE and the round-robin pointer (last granted channel) is set to 3, so channel 0 has first priority. Reset mid-transaction abandons it and issues no ack. The co-processor shares the same reset.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any eligible req is set, grant the first requester after the pointer in round-robin order. At that edge, register cp_check = grant index and cp_data = that channel's sample, update the pointer, and go to ISSUE.
- ISSUE: lasts one cycle, during which the co-processor samples its inputs. At the ending edge, set ack[grant] high for exactly the next cycle and go to CAPTURE.
- CAPTURE: cp_q is valid in this cycle. At the ending edge:
  - if cp_q is 1, set event_flags[grant] and increment evt_count, saturating at all-ones;
  - if another eligible req is pending, grant it directly (back-to-back, going to ISSUE); otherwise go to IDLE.
- Eligibility: in CAPTURE, the channel currently being acked is masked from arbitration, because its req is still high that cycle.
- Throughput: 2 cycles per transaction back-to-back; grant-to-ack latency is 2 cycles.
- cp_check and cp_data hold their last values in IDLE. The co-processor re-evaluates every edge and holding is harmless: stored value equals data, so Q reads 0.
- Simultaneous set and event_clr on the same flag bit: set wins.
- Simultaneous increment and cnt_clr: clear wins, result 0.
- req deasserted before ack (protocol violation): the transaction still completes with the latched sample.

Decomposition:
- Shared package sensor_pkg holds:
  - constants NUM_CH=4, DATA_W=8, CH_W=2;
  - the state enum (IDLE, ISSUE, CAPTURE).
- One natural sub-module, rr_arbiter4: a 4-way round-robin priority pick with mask input, pointer input and one-hot/index output. It is combinational; the pointer register stays in the parent.

Test Plan:
- Reset, then req=4'b0001 with sample0=5: cp_check=0 and cp_data=5 in ISSUE; ack[0] pulses 2 cycles after grant; cp_q=1 → event_flags=4'b0001, evt_count=1; irq=1 when irq_en=1.
- Same channel 0, sample 7 (stored value 5, diff 2): cp_q=0, flags unchanged, evt_count stays 1. event_clr=4'b0001 → flags=0, irq=0.
- All four req high with samples 10, 20, 30, 40: grants in order 0, 1, 2, 3 back-to-back, one ack every 2 cycles; all 4 flags set; evt_count rises by 4.
- Channel 2 event capture coincident with event_clr[2]=1: flag ends at 1. Separately, cnt_clr in the same cycle as an increment: evt_count=0.
- Preload evt_count to 255 via repeated events, then one more event: evt_count stays 255.
- Assert reset during ISSUE of a channel-1 transaction: no ack[1], all outputs 0. Next grant is channel 0 if req[0]=1.
